param_seq_detector: RTL

//  Runtime-programmable serial pattern detector with a Moore-registered output.

---
 rtl/param_seq_det_pkg.sv | 15 +
 rtl/seq_match_counter.sv | 22 ++
 rtl/param_seq_detector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/param_seq_det_pkg.sv
// Shared types and sizing helpers for the programmable serial pattern detector.
package param_seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HUNT = 2'd2,
        S_HIT  = 2'd3
    } state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a synchronous clear beats a simultaneous increment.
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector with a registered (Moore) detect pulse
// and a saturating match counter.
//
// state  | meaning
// S_IDLE | detector disabled, history empty
// S_FILL | collecting bits, fewer than len since the last clear
// S_HUNT | history full enough, last bit did not match
// S_HIT  | last accepted bit completed a match (detected high)
module param_seq_detector
    import param_seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0000_1011,
    parameter int                 DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count
);

    localparam int               LEN_W     = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pattern_q, hist, hist_next;
    logic [LEN_W-1:0]   len_q, len_clamped, fill, fill_next;
    logic               overlap_q;
    logic               accepted, match;
    logic [MAX_LEN:0]   mask_wide;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_V) begin
            len_clamped = MAX_LEN_V;
        end
    end

    assign accepted  = enable & in_valid & ~cfg_we;
    assign hist_next = {hist[MAX_LEN-2:0], in_bit};
    assign fill_next = (fill >= MAX_LEN_V) ? fill : fill + LEN_W'(1);

    // One extra bit so len == MAX_LEN still yields an all-ones mask.
    assign mask_wide = ((MAX_LEN+1)'(1) << len_q) - (MAX_LEN+1)'(1);
    assign match     = accepted && (fill_next >= len_q) &&
                       (((({1'b0, hist_next}) ^ ({1'b0, pattern_q})) & mask_wide) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_clamped;
            overlap_q <= cfg_overlap;
        end
    end

    // A non-overlapping match restarts the fill count so the next match needs len fresh bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            hist  <= '0;
            fill  <= '0;
        end else begin
            state <= state_next;
            if (!enable || cfg_we) begin
                hist <= '0;
                fill <= '0;
            end else if (accepted) begin
                hist <= hist_next;
                fill <= (match && !overlap_q) ? '0 : fill_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = S_IDLE;
        end else if (cfg_we) begin
            state_next = S_FILL;
        end else if (accepted) begin
            if (match) begin
                state_next = S_HIT;
            end else if (fill_next >= len_q) begin
                state_next = S_HUNT;
            end else begin
                state_next = S_FILL;
            end
        end else begin
            unique case (state)
                S_IDLE:  state_next = S_FILL;
                S_HIT:   state_next = overlap_q ? S_HUNT : S_FILL;
                S_FILL:  state_next = S_FILL;
                S_HUNT:  state_next = S_HUNT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign detected = (state == S_HIT);

    seq_match_counter #(.CNT_W(CNT_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (match),
        .count (match_count)
    );

endmodule
